// File: rtl/seg_update_sched_pkg.sv
// seg_update_sched_pkg: state encodings and field geometry shared by the display write scheduler
package seg_update_sched_pkg;
  localparam int FIELD_W = 8;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DONE = 2'd1;
  localparam logic [1:0] S_HOLDOFF   = 2'd2;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/seg_update_sched.sv
// seg_update_sched: shadows per-requester display bytes and issues one paced, coalesced write at a time
module seg_update_sched
  import seg_update_sched_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int HOLDOFF_CYC = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_we,
  input  logic [FIELD_W*NUM_SRC-1:0]   src_data,
  input  logic                         force_refresh,
  input  logic                         seg_rdy,
  input  logic                         seg_done,
  output logic                         seg_wen,
  output logic [FIELD_W*NUM_SRC-1:0]   seg_data,
  output logic                         busy,
  output logic [NUM_SRC-1:0]           ovr_flags,
  output logic                         timeout_err,
  input  logic                         err_clr
);
  localparam int W = FIELD_W * NUM_SRC;
  localparam int CNT_W = $clog2(max_i(HOLDOFF_CYC, TIMEOUT_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       shadow_q, shadow_d, data_q, data_d;
  logic [NUM_SRC-1:0] dirty_q, dirty_d, ovr_q, ovr_d;
  logic               wen_q, tmo_q, tmo_d, tmo_set, issue;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_field
    assign shadow_d[i*FIELD_W +: FIELD_W] = src_we[i] ? src_data[i*FIELD_W +: FIELD_W]
                                                      : shadow_q[i*FIELD_W +: FIELD_W];
  end
  // Issue snapshots the shadow including same-cycle writes, so those never count as overruns
  assign issue   = state_q == S_IDLE && seg_rdy && (|dirty_q || force_refresh || |src_we);
  assign dirty_d = issue ? '0 : dirty_q | src_we | {NUM_SRC{force_refresh}};
  assign ovr_d   = (err_clr ? '0 : ovr_q) | (src_we & dirty_q & {NUM_SRC{!issue}});
  assign tmo_d   = (err_clr ? 1'b0 : tmo_q) | tmo_set;
  assign data_d  = issue ? shadow_d : data_q;
  // One counter: counts up for the done timeout, then down for the holdoff gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = issue ? S_WAIT_DONE : S_IDLE;
        cnt_d   = issue ? '0 : cnt_q;
      end
      S_WAIT_DONE: begin
        tmo_set = !seg_done && cnt_q == TMO_LAST;
        state_d = seg_done || tmo_set ? S_HOLDOFF : S_WAIT_DONE;
        cnt_d   = seg_done || tmo_set ? HOLD_LOAD : cnt_q + 1'b1;
      end
      S_HOLDOFF: begin
        state_d = cnt_q == '0 ? S_IDLE : S_HOLDOFF;
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      dirty_q  <= '0;
      ovr_q    <= '0;
      wen_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      dirty_q  <= dirty_d;
      ovr_q    <= ovr_d;
      wen_q    <= issue;
      tmo_q    <= tmo_d;
    end
  end
  assign seg_wen     = wen_q;
  assign seg_data    = data_q;
  assign busy        = state_q != S_IDLE;
  assign ovr_flags   = ovr_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_seg_update_sched.sv
// tb_seg_update_sched: directed vector table plus hand sequences for pacing, timeout and reset
module tb_seg_update_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_we;
  logic [23:0] src_data;
  logic        force_refresh, seg_rdy, seg_done, err_clr;
  logic        seg_wen, busy, timeout_err;
  logic [23:0] seg_data;
  logic [2:0]  ovr_flags;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [2:0]  we;
    logic [23:0] d;
    logic        frc, rdy, done, clr;
    logic        wen;
    logic [23:0] data;
    logic        busy;
    logic [2:0]  ovr;
    logic        tmo;
  } vec_t;
  vec_t vecs [9];
  seg_update_sched dut (
    .clk(clk), .rst_n(rst_n), .src_we(src_we), .src_data(src_data),
    .force_refresh(force_refresh), .seg_rdy(seg_rdy), .seg_done(seg_done),
    .seg_wen(seg_wen), .seg_data(seg_data), .busy(busy), .ovr_flags(ovr_flags),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clear_strobes();
    src_we = '0;
    force_refresh = 1'b0;
    seg_done = 1'b0;
    err_clr = 1'b0;
  endtask
  task automatic apply(input int i);
    src_we = vecs[i].we;
    src_data = vecs[i].d;
    force_refresh = vecs[i].frc;
    seg_rdy = vecs[i].rdy;
    seg_done = vecs[i].done;
    err_clr = vecs[i].clr;
    step();
    clear_strobes();
    chk($sformatf("vec%0d wen", i), 32'(seg_wen), 32'(vecs[i].wen));
    chk($sformatf("vec%0d data", i), 32'(seg_data), 32'(vecs[i].data));
    chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    chk($sformatf("vec%0d ovr", i), 32'(ovr_flags), 32'(vecs[i].ovr));
    chk($sformatf("vec%0d tmo", i), 32'(timeout_err), 32'(vecs[i].tmo));
  endtask
  task automatic wait_idle(input string name, input int exp_n);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask
  task automatic count_wen(input int n, output int cnt, output logic [23:0] last);
    cnt = 0;
    last = '0;
    for (int k = 0; k < n; k++) begin
      step();
      if (seg_wen) begin
        cnt++;
        last = seg_data;
      end
    end
  endtask
  task automatic finish_write();
    seg_done = 1'b1;
    step();
    seg_done = 1'b0;
    wait_idle("holdoff_len", 16);
  endtask
  task automatic check_all_zero(input string name);
    chk({name, " wen"}, 32'(seg_wen), 32'd0);
    chk({name, " data"}, 32'(seg_data), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " ovr"}, 32'(ovr_flags), 32'd0);
    chk({name, " tmo"}, 32'(timeout_err), 32'd0);
  endtask
  initial begin
    int cnt;
    logic [23:0] last;
    logic bad;
    //          we      d            frc   rdy   done  clr   wen   data          busy  ovr     tmo
    vecs[0] = '{3'b001, 24'h00005A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00005A, 1'b1, 3'b000, 1'b0};
    vecs[1] = '{3'b000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00005A, 1'b1, 3'b000, 1'b0};
    vecs[2] = '{3'b000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00005A, 1'b1, 3'b000, 1'b0};
    vecs[3] = '{3'b000, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00005A, 1'b1, 3'b000, 1'b0};
    vecs[4] = '{3'b001, 24'h0000A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000A5, 1'b1, 3'b000, 1'b0};
    vecs[5] = '{3'b000, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0000A5, 1'b1, 3'b000, 1'b0};
    vecs[6] = '{3'b010, 24'h001100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000A5, 1'b1, 3'b000, 1'b0};
    vecs[7] = '{3'b010, 24'h002200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000A5, 1'b1, 3'b010, 1'b0};
    vecs[8] = '{3'b100, 24'h330000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000A5, 1'b1, 3'b010, 1'b0};
    rst_n = 1'b0;
    seg_rdy = 1'b0;
    src_data = '0;
    clear_strobes();
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(i);
    wait_idle("t1 holdoff_len", 16);
    // Writes during holdoff coalesce into one issue on return to IDLE
    for (int i = 4; i < 9; i++) apply(i);
    count_wen(40, cnt, last);
    chk("t2 wen_count", 32'(cnt), 32'd1);
    chk("t2 data", 32'(last), 32'h3322A5);
    chk("t2 ovr", 32'(ovr_flags), 32'b010);
    finish_write();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3 ovr_clr", 32'(ovr_flags), 32'd0);
    seg_rdy = 1'b0;
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    count_wen(50, cnt, last);
    chk("t3 no_wen_unready", 32'(cnt), 32'd0);
    chk("t3 tmo", 32'(timeout_err), 32'd0);
    chk("t3 busy", 32'(busy), 32'd0);
    seg_rdy = 1'b1;
    step();
    chk("t3 wen", 32'(seg_wen), 32'd1);
    chk("t3 data", 32'(seg_data), 32'h3322A5);
    finish_write();
    // Same-cycle write and issue: byte rides along, no overrun, nothing left dirty
    seg_rdy = 1'b0;
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    seg_rdy = 1'b1;
    src_we = 3'b001;
    src_data = 24'h000077;
    step();
    src_we = '0;
    chk("t5 wen", 32'(seg_wen), 32'd1);
    chk("t5 data", 32'(seg_data), 32'h332277);
    chk("t5 ovr", 32'(ovr_flags), 32'd0);
    finish_write();
    count_wen(20, cnt, last);
    chk("t5 no_second_wen", 32'(cnt), 32'd0);
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    chk("t4 wen", 32'(seg_wen), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 1023; k++) begin
      step();
      if (timeout_err || !busy) bad = 1'b1;
    end
    chk("t4 early_timeout", 32'(bad), 32'd0);
    step();
    chk("t4 tmo_set", 32'(timeout_err), 32'd1);
    chk("t4 busy_holdoff", 32'(busy), 32'd1);
    wait_idle("t4 holdoff_len", 16);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4 tmo_clr", 32'(timeout_err), 32'd0);
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
    for (int k = 0; k < 1023; k++) step();
    seg_done = 1'b1;
    step();
    seg_done = 1'b0;
    chk("t4 done_last_cycle tmo", 32'(timeout_err), 32'd0);
    chk("t4 done_last_cycle busy", 32'(busy), 32'd1);
    wait_idle("t4 holdoff_len2", 16);
    src_we = 3'b100;
    src_data = 24'h440000;
    step();
    chk("t6 wen", 32'(seg_wen), 32'd1);
    chk("t6 data", 32'(seg_data), 32'h442277);
    src_we = 3'b001;
    src_data = 24'h000001;
    step();
    src_we = '0;
    chk("t6 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check_all_zero("t6 reset");
    rst_n = 1'b1;
    count_wen(20, cnt, last);
    chk("t6 no_wen_after_reset", 32'(cnt), 32'd0);
    chk("t6 busy_after_reset", 32'(busy), 32'd0);
    src_we = 3'b010;
    src_data = 24'h005500;
    step();
    src_we = '0;
    chk("t6 new_wen", 32'(seg_wen), 32'd1);
    chk("t6 new_data", 32'(seg_data), 32'h005500);
    finish_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
